// File: rtl/stream_demux_pkg.sv
// Shared types for the registered 1-to-N stream demultiplexer.
//   state_e : packet-routing FSM state
//     ST_IDLE   - between packets; route follows sel_i
//     ST_LOCKED - inside a multi-beat packet; route follows lock_sel
package stream_demux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry output register for a single demux channel.
// Holds one beat (data + last) until the consumer takes it. A load and a
// drain in the same cycle replace the beat, so the slice sustains one beat
// per cycle. Data and last read as zero whenever the slice is empty.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         write data_i/last_i into the slice this cycle
//   data_i, last_i beat to store
//   ready_i        consumer ready
//   can_take_o     slice empty or draining this cycle
//   valid_o        slice holds a beat
//   data_o, last_o stored beat, zero when empty
module stream_reg_slice #(
  parameter int DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              can_take_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: the payload needs no reset; the zero-fill below hides it while
  // valid_q is low, so only the valid bit carries reset state.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      data_q <= data_i;
      last_q <= last_i;
    end
  end

  assign can_take_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign data_o     = valid_q ? data_q : '0;
  assign last_o     = valid_q && last_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer with packet-locked routing.
// The first beat of a packet picks the channel from sel_i; later beats of
// the same packet follow that channel until the last beat. Each channel
// has its own one-entry register, so channels drain independently.
// A select beyond CHANNELS-1 accepts and drops the whole packet and
// pulses err_o once per dropped beat.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   s_data_i/s_valid_i/s_last_i  input stream, s_ready_o back-pressure
//   sel_i                        destination, used on a packet's first beat
//   m_data_o/m_valid_o/m_last_o  per-channel output streams
//   m_ready_i                    per-channel consumer ready
//   busy_o                       a packet is locked to a channel
//   err_o                        one-cycle pulse after a dropped beat
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W   = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DATA_W-1:0]                s_data_i,
  input  logic                             s_valid_i,
  input  logic                             s_last_i,
  output logic                             s_ready_o,
  input  logic [SEL_W-1:0]                 sel_i,
  output logic [CHANNELS-1:0][DATA_W-1:0]  m_data_o,
  output logic [CHANNELS-1:0]              m_valid_o,
  output logic [CHANNELS-1:0]              m_last_o,
  input  logic [CHANNELS-1:0]              m_ready_i,
  output logic                             busy_o,
  output logic                             err_o
);

  state_e              state_q;
  logic [SEL_W-1:0]    lock_sel_q;
  logic                err_q;
  logic [SEL_W-1:0]    target;
  logic [CHANNELS-1:0] sel_oh;
  logic [CHANNELS-1:0] can_take;
  logic [CHANNELS-1:0] load;
  logic                in_range;
  logic                accept;

  assign target = (state_q == ST_LOCKED) ? lock_sel_q : sel_i;

  // NOTE: give every always_comb output a default before any conditional
  // assignment so no path leaves it unassigned and infers a latch.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_oh[k] = (target == SEL_W'(k));
    end
  end

  // An all-zero one-hot means the select points past the last channel.
  assign in_range  = |sel_oh;
  assign s_ready_o = !rst_i && (!in_range || |(sel_oh & can_take));
  assign accept    = s_valid_i && s_ready_o;
  assign load      = accept ? sel_oh : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
      case (state_q)
        ST_IDLE: begin
          if (accept && !s_last_i) begin
            state_q    <= ST_LOCKED;
            lock_sel_q <= sel_i;
          end
        end
        ST_LOCKED: begin
          if (accept && s_last_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == ST_LOCKED);
  assign err_o  = err_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slice
    stream_reg_slice #(
      .DATA_W(DATA_W)
    ) u_slice (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (load[k]),
      .data_i    (s_data_i),
      .last_i    (s_last_i),
      .ready_i   (m_ready_i[k]),
      .can_take_o(can_take[k]),
      .valid_o   (m_valid_o[k]),
      .data_o    (m_data_o[k]),
      .last_o    (m_last_o[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn. Two instances share the input
// stream: a 4-channel one and a 3-channel one, where select 3 is out of
// range. A behavioural model per instance predicts ready, outputs, busy
// and err every cycle; directed sequences come first, then random traffic.
module tb_stream_demux_1xn;

  typedef struct packed {
    logic            locked;
    logic [1:0]      lock_ch;
    logic [3:0]      v;
    logic [3:0][3:0] d;
    logic [3:0]      l;
    logic            err;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_last  = 1'b0;
  logic [3:0] s_data  = '0;
  logic [1:0] sel     = '0;
  logic [3:0] mr4     = '0;
  logic [2:0] mr3     = '0;

  logic            rdy4, busy4, err4;
  logic [3:0][3:0] md4;
  logic [3:0]      mv4, ml4;
  logic            rdy3, busy3, err3;
  logic [2:0][3:0] md3;
  logic [2:0]      mv3, ml3;

  stream_demux_1xn #(.DATA_W(4), .CHANNELS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid),
    .s_last_i(s_last), .s_ready_o(rdy4), .sel_i(sel), .m_data_o(md4),
    .m_valid_o(mv4), .m_last_o(ml4), .m_ready_i(mr4), .busy_o(busy4),
    .err_o(err4)
  );

  stream_demux_1xn #(.DATA_W(4), .CHANNELS(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid),
    .s_last_i(s_last), .s_ready_o(rdy3), .sel_i(sel), .m_data_o(md3),
    .m_valid_o(mv3), .m_last_o(ml3), .m_ready_i(mr3), .busy_o(busy3),
    .err_o(err3)
  );

  int     checks    = 0;
  int     failures  = 0;
  int     cyc       = 0;
  bit     model_ok  = 1'b0;
  logic   rdy4_seen = 1'b0;
  model_t m4        = '0;
  model_t m3        = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Destination of the beat on offer: locked channel or live select.
  function automatic int model_target(model_t m, logic [1:0] sel_v);
    return m.locked ? int'(m.lock_ch) : int'(sel_v);
  endfunction

  function automatic logic model_ready(model_t m, int nch, logic r,
                                       logic [1:0] sel_v, logic [3:0] mr);
    int t;
    t = model_target(m, sel_v);
    if (r) return 1'b0;
    if (t >= nch) return 1'b1;
    return !m.v[t] || mr[t];
  endfunction

  function automatic model_t model_next(model_t m, int nch, logic r,
                                        logic vld, logic [3:0] dat,
                                        logic lst, logic [1:0] sel_v,
                                        logic [3:0] mr);
    model_t n;
    int     t;
    logic   acc;
    n = m;
    if (r) return '0;
    t     = model_target(m, sel_v);
    acc   = vld && model_ready(m, nch, r, sel_v, mr);
    n.err = acc && (t >= nch);
    for (int k = 0; k < 4; k++) begin
      if (m.v[k] && mr[k]) n.v[k] = 1'b0;
    end
    if (acc && t < nch) begin
      n.v[t] = 1'b1;
      n.d[t] = dat;
      n.l[t] = lst;
    end
    if (!m.locked && acc && !lst) begin
      n.locked  = 1'b1;
      n.lock_ch = sel_v;
    end else if (m.locked && acc && lst) begin
      n.locked = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [15:0] exp_data(model_t m);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (m.v[k]) r[k*4 +: 4] = m.d[k];
    end
    return r;
  endfunction

  // One clock: drive at the falling edge, compare before the rising edge,
  // advance the models, return 1 time unit after the rising edge.
  task automatic step(input logic r, input logic v, input logic [3:0] dat,
                      input logic lst, input logic [1:0] sv,
                      input logic [3:0] mr);
    logic [15:0] ed4, ed3;
    @(negedge clk);
    rst = r; s_valid = v; s_data = dat; s_last = lst; sel = sv;
    mr4 = mr; mr3 = mr[2:0];
    #1;
    cyc++;
    rdy4_seen = rdy4;
    check("ready4", rdy4, model_ready(m4, 4, r, sv, mr));
    check("ready3", rdy3, model_ready(m3, 3, r, sv, mr));
    if (model_ok) begin
      ed4 = exp_data(m4);
      ed3 = exp_data(m3);
      check("valid4", mv4, m4.v);
      check("data4",  md4, ed4);
      check("last4",  ml4, m4.l & m4.v);
      check("busy4",  busy4, m4.locked);
      check("err4",   err4, m4.err);
      check("valid3", mv3, m3.v[2:0]);
      check("data3",  md3, ed3[11:0]);
      check("last3",  ml3, m3.l[2:0] & m3.v[2:0]);
      check("busy3",  busy3, m3.locked);
      check("err3",   err3, m3.err);
    end
    m4 = model_next(m4, 4, r, v, dat, lst, sv, mr);
    m3 = model_next(m3, 3, r, v, dat, lst, sv, mr);
    if (r) model_ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with a valid beat on offer.
    step(1'b1, 1'b1, 4'h5, 1'b1, 2'd0, 4'hF);
    step(1'b1, 1'b1, 4'h5, 1'b1, 2'd0, 4'hF);
    check("rst_valid", mv4, 4'b0000);
    check("rst_data",  md4, 16'h0000);
    check("rst_busy",  busy4, 1'b0);

    // Single-beat packet to channel 2.
    step(1'b0, 1'b1, 4'hA, 1'b1, 2'd2, 4'hF);
    check("single_valid", mv4, 4'b0100);
    check("single_data",  md4, 16'h0A00);
    check("single_busy",  busy4, 1'b0);

    // Three-beat packet locked to channel 1 despite sel changing.
    step(1'b0, 1'b1, 4'h1, 1'b0, 2'd1, 4'hF);
    check("lock_busy0",  busy4, 1'b1);
    check("lock_valid0", mv4, 4'b0010);
    step(1'b0, 1'b1, 4'h2, 1'b0, 2'd3, 4'hF);
    check("lock_data1",  md4, 16'h0020);
    step(1'b0, 1'b1, 4'h3, 1'b1, 2'd3, 4'hF);
    check("lock_data2",  md4, 16'h0030);
    check("lock_last2",  ml4, 4'b0010);
    check("lock_busy2",  busy4, 1'b0);

    // Backpressure on channel 0.
    step(1'b0, 1'b1, 4'h7, 1'b1, 2'd0, 4'hE);
    check("bp_first", mv4, 4'b0001);
    step(1'b0, 1'b1, 4'h8, 1'b1, 2'd0, 4'hE);
    check("bp_stall", rdy4_seen, 1'b0);
    check("bp_hold",  md4, 16'h0007);
    step(1'b0, 1'b1, 4'h8, 1'b1, 2'd0, 4'hF);
    check("bp_resume", rdy4_seen, 1'b1);
    check("bp_data",   md4, 16'h0008);
    step(1'b0, 1'b1, 4'h9, 1'b1, 2'd0, 4'hF);
    check("bp_b2b",    rdy4_seen, 1'b1);
    check("bp_data2",  md4, 16'h0009);

    // Channel 0 stalled; channel 3 still flows. On the 3-channel instance
    // the same beat is out of range and must be dropped with err.
    step(1'b0, 1'b1, 4'hC, 1'b1, 2'd3, 4'hE);
    check("indep_rdy",   rdy4_seen, 1'b1);
    check("indep_data",  md4, 16'hC009);
    check("indep_valid", mv4, 4'b1001);
    check("drop_err3",   err3, 1'b1);
    check("drop_err4",   err4, 1'b0);
    check("drop_valid3", mv3, 3'b001);
    step(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'hF);
    check("drop_pulse",  err3, 1'b0);

    // Reset in the middle of a packet.
    step(1'b0, 1'b1, 4'hD, 1'b0, 2'd1, 4'hF);
    check("mid_busy",  busy4, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'hF);
    check("mid_rst_busy",  busy4, 1'b0);
    check("mid_rst_valid", mv4, 4'b0000);
    check("mid_rst_err",   err4, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] mr;
      for (int b = 0; b < 4; b++) mr[b] = ($urandom_range(9) < 7);
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
           4'($urandom), ($urandom_range(2) == 0), 2'($urandom), mr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
